cmos_pixel_packer: RTL and testbench



---
 rtl/cmos_pixel_packer.sv | 153 +++++++++++++++
 tb/tb_cmos_pixel_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pixel_packer.sv
// OV5640 capture stage: pairs camera bytes into RGB565 pixels, tags them with x/y
// and frame/line markers, skips start-up frames and flags malformed lines/frames.
module cmos_pixel_packer #(
   parameter int H_RES       = 1280,
   parameter int V_RES       = 720,
   parameter int SKIP_FRAMES = 10
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_enable,
   input  logic        I_vsync,
   input  logic        I_href,
   input  logic [7:0]  I_data,
   output logic        O_pix_valid,
   output logic [15:0] O_pix_data,
   output logic [23:0] O_rgb888,
   output logic [11:0] O_x,
   output logic [11:0] O_y,
   output logic        O_sof,
   output logic        O_eol,
   output logic [15:0] O_frame_cnt,
   output logic        O_err_odd,
   output logic        O_err_size,
   output logic [1:0]  O_state
);

   // Debug view of the FSM: 0 IDLE, 1 SKIP, 2 WAIT_VS, 3 ACTIVE.
   typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, WAIT_VS = 2'd2, ACTIVE = 2'd3} state_t;

   localparam logic [11:0] H_LIM     = 12'(H_RES);
   localparam logic [11:0] V_LIM     = 12'(V_RES);
   localparam logic [15:0] SKIP_LAST = 16'(SKIP_FRAMES - 1);

   state_t      state;
   logic        vs_d, hs_d, phase;
   logic [7:0]  high_byte;
   logic [11:0] x_cnt, y_cnt;
   logic [15:0] skip_cnt;
   logic        vs_rise, vs_fall, hs_fall;
   logic [15:0] pix_word;

   assign vs_rise  = I_vsync & ~vs_d;
   assign vs_fall  = ~I_vsync & vs_d;
   assign hs_fall  = ~I_href & hs_d;
   assign pix_word = {high_byte, I_data};
   assign O_state  = state;

   function automatic logic [23:0] expand(input logic [15:0] p);
      return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
   endfunction

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state       <= IDLE;
         vs_d        <= 1'b0;
         hs_d        <= 1'b0;
         phase       <= 1'b0;
         high_byte   <= 8'd0;
         x_cnt       <= 12'd0;
         y_cnt       <= 12'd0;
         skip_cnt    <= 16'd0;
         O_pix_valid <= 1'b0;
         O_pix_data  <= 16'd0;
         O_rgb888    <= 24'd0;
         O_x         <= 12'd0;
         O_y         <= 12'd0;
         O_sof       <= 1'b0;
         O_eol       <= 1'b0;
         O_frame_cnt <= 16'd0;
         O_err_odd   <= 1'b0;
         O_err_size  <= 1'b0;
      end else begin
         vs_d        <= I_vsync;
         hs_d        <= I_href;
         O_pix_valid <= 1'b0;
         O_sof       <= 1'b0;
         O_eol       <= 1'b0;
         if (!I_enable) begin
            // Losing configuration abandons any partial frame without counting it.
            state    <= IDLE;
            skip_cnt <= 16'd0;
            phase    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  skip_cnt <= 16'd0;
                  state    <= (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
               end
               SKIP: begin
                  if (vs_rise) begin
                     if (skip_cnt == SKIP_LAST) begin
                        state    <= WAIT_VS;
                        skip_cnt <= 16'd0;
                     end else begin
                        skip_cnt <= skip_cnt + 16'd1;
                     end
                  end
               end
               WAIT_VS: begin
                  phase <= 1'b0;
                  if (vs_fall) begin
                     state      <= ACTIVE;
                     x_cnt      <= 12'd0;
                     y_cnt      <= 12'd0;
                     O_err_odd  <= 1'b0;
                     O_err_size <= 1'b0;
                  end
               end
               ACTIVE: begin
                  if (vs_rise) begin
                     // Frame end wins over a simultaneous href fall: partial line is not counted.
                     state       <= WAIT_VS;
                     O_frame_cnt <= O_frame_cnt + 16'd1;
                     if (y_cnt != V_LIM) O_err_size <= 1'b1;
                  end else if (I_href) begin
                     phase <= ~phase;
                     if (!phase) begin
                        high_byte <= I_data;
                     end else begin
                        if (x_cnt < H_LIM && y_cnt < V_LIM) begin
                           O_pix_valid <= 1'b1;
                           O_pix_data  <= pix_word;
                           O_rgb888    <= expand(pix_word);
                           O_x         <= x_cnt;
                           O_y         <= y_cnt;
                           O_sof       <= (x_cnt == 12'd0) && (y_cnt == 12'd0);
                        end else begin
                           O_err_size <= 1'b1;
                        end
                        x_cnt <= sat_inc(x_cnt);
                     end
                  end else begin
                     phase <= 1'b0;
                     if (hs_fall) begin
                        O_eol <= (y_cnt < V_LIM);
                        if (phase) O_err_odd <= 1'b1;
                        if (x_cnt != H_LIM) O_err_size <= 1'b1;
                        x_cnt <= 12'd0;
                        y_cnt <= sat_inc(y_cnt);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Directed bench for cmos_pixel_packer with a small H_RES/V_RES/SKIP_FRAMES setup;
// expected pixels are queued as bytes are driven and checked when strobes appear.
module tb_cmos_pixel_packer;

   localparam int H = 4;
   localparam int V = 2;
   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst, enable, vsync, href;
   logic [7:0]  data;
   logic        pix_valid, sof, eol, err_odd, err_size;
   logic [15:0] pix_data, frame_cnt;
   logic [23:0] rgb888;
   logic [11:0] x, y;
   logic [1:0]  state;

   cmos_pixel_packer #(.H_RES(H), .V_RES(V), .SKIP_FRAMES(S)) dut (
      .I_clk(clk), .I_rst(rst), .I_enable(enable), .I_vsync(vsync), .I_href(href),
      .I_data(data), .O_pix_valid(pix_valid), .O_pix_data(pix_data), .O_rgb888(rgb888),
      .O_x(x), .O_y(y), .O_sof(sof), .O_eol(eol), .O_frame_cnt(frame_cnt),
      .O_err_odd(err_odd), .O_err_size(err_size), .O_state(state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int pix_cnt = 0;
   int eol_cnt = 0;
   int m_x = 0, m_y = 0;
   bit m_cap = 1'b0;
   int pix0, eol0;
   // {data[15:0], x[11:0], y[11:0], sof}
   logic [40:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_rgb(input logic [15:0] p);
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = p[15:11]; g = p[10:5]; b = p[4:0];
      return {r, r[4:2], g, g[5:4], b, b[4:2]};
   endfunction

   always @(negedge clk) begin
      logic [40:0] e;
      if (eol === 1'b1) eol_cnt++;
      if (pix_valid === 1'b1) begin
         pix_cnt++;
         checks++;
         assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL unexpected_pixel observed=%0h expected=none", pix_data);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pix_data", 32'(pix_data), 32'(e[40:25]));
            chk("rgb888", 32'(rgb888), 32'(exp_rgb(e[40:25])));
            chk("pix_x", 32'(x), 32'(e[24:13]));
            chk("pix_y", 32'(y), 32'(e[12:1]));
            chk("pix_sof", 32'(sof), 32'(e[0]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      href = 1'b1;
      data = b;
      step();
   endtask

   task automatic send_pixel(input logic [15:0] p);
      bit acc;
      acc = m_cap && (m_x < H) && (m_y < V);
      send_byte(p[15:8]);
      if (acc) exp_q.push_back({p, 12'(m_x), 12'(m_y), (m_x == 0) && (m_y == 0)});
      send_byte(p[7:0]);
      m_x++;
   endtask

   task automatic end_line();
      href = 1'b0;
      m_x = 0;
      m_y++;
      repeat (3) step();
   endtask

   task automatic send_line(input int npix);
      for (int i = 0; i < npix; i++) send_pixel(16'($urandom_range(0, 16'hFFFF)));
      end_line();
   endtask

   task automatic vs_rise_steps();
      href = 1'b0;
      vsync = 1'b1;
      repeat (3) step();
   endtask

   task automatic vs_fall_steps();
      vsync = 1'b0;
      m_x = 0;
      m_y = 0;
      repeat (3) step();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
      chk({tag, "_data"}, 32'(pix_data), 32'd0);
      chk({tag, "_rgb"}, 32'(rgb888), 32'd0);
      chk({tag, "_x"}, 32'(x), 32'd0);
      chk({tag, "_y"}, 32'(y), 32'd0);
      chk({tag, "_sof"}, 32'(sof), 32'd0);
      chk({tag, "_eol"}, 32'(eol), 32'd0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      chk({tag, "_err_odd"}, 32'(err_odd), 32'd0);
      chk({tag, "_err_size"}, 32'(err_size), 32'd0);
      chk({tag, "_state"}, 32'(state), 32'd0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'd0;
      repeat (3) step();
      check_zero("reset");
      rst = 1'b0;
      step();

      // Two frames are discarded after enable.
      enable = 1'b1;
      m_cap = 1'b0;
      repeat (2) step();
      chk("state_skip", 32'(state), 32'd1);
      send_line(H); send_line(H);
      vs_rise_steps(); vs_fall_steps();
      send_line(H); send_line(H);
      vs_rise_steps();
      chk("state_wait_vs", 32'(state), 32'd2);
      vs_fall_steps();
      chk("state_active", 32'(state), 32'd3);
      chk("skip_strobes", 32'(pix_cnt), 32'd0);

      // Delivered frame with directed byte-order / expansion values.
      m_cap = 1'b1;
      pix0 = pix_cnt; eol0 = eol_cnt;
      send_pixel(16'hF81F);
      chk("f81f_data", 32'(pix_data), 32'h0000F81F);
      chk("f81f_rgb", 32'(rgb888), 32'h00FF00FF);
      send_pixel(16'h8410);
      chk("8410_data", 32'(pix_data), 32'h00008410);
      chk("8410_rgb", 32'(rgb888), 32'h00848284);
      send_pixel(16'($urandom_range(0, 16'hFFFF)));
      send_pixel(16'($urandom_range(0, 16'hFFFF)));
      end_line();
      send_line(H);
      vs_rise_steps();
      chk("good_strobes", 32'(pix_cnt - pix0), 32'd8);
      chk("good_eol", 32'(eol_cnt - eol0), 32'd2);
      chk("good_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("good_err_odd", 32'(err_odd), 32'd0);
      chk("good_err_size", 32'(err_size), 32'd0);
      vs_fall_steps();

      // Odd line: 9 bytes, the orphan byte is discarded.
      pix0 = pix_cnt;
      for (int i = 0; i < 4; i++) send_pixel(16'($urandom_range(0, 16'hFFFF)));
      send_byte(8'hAB);
      end_line();
      chk("odd_strobes", 32'(pix_cnt - pix0), 32'd4);
      chk("odd_err_odd", 32'(err_odd), 32'd1);
      vs_rise_steps();
      chk("odd_err_odd_held", 32'(err_odd), 32'd1);
      chk("odd_err_size", 32'(err_size), 32'd1);
      chk("odd_frame_cnt", 32'(frame_cnt), 32'd2);
      vs_fall_steps();
      chk("odd_err_odd_clr", 32'(err_odd), 32'd0);
      chk("odd_err_size_clr", 32'(err_size), 32'd0);

      // Long frame: 6 pixels per line, 3 lines.
      pix0 = pix_cnt; eol0 = eol_cnt;
      send_line(6); send_line(6); send_line(6);
      chk("long_strobes", 32'(pix_cnt - pix0), 32'd8);
      chk("long_eol", 32'(eol_cnt - eol0), 32'd2);
      chk("long_err_size", 32'(err_size), 32'd1);
      vs_rise_steps();
      chk("long_frame_cnt", 32'(frame_cnt), 32'd3);
      vs_fall_steps();

      // Vsync rises in the middle of line 2.
      pix0 = pix_cnt; eol0 = eol_cnt;
      send_line(H);
      send_pixel(16'h0F0F);
      send_pixel(16'hF0F0);
      vs_rise_steps();
      chk("abort_eol", 32'(eol_cnt - eol0), 32'd1);
      chk("abort_strobes", 32'(pix_cnt - pix0), 32'd6);
      chk("abort_frame_cnt", 32'(frame_cnt), 32'd4);
      chk("abort_err_size", 32'(err_size), 32'd1);
      vs_fall_steps();

      // Enable drops mid-frame.
      pix0 = pix_cnt;
      send_pixel(16'h1234);
      enable = 1'b0;
      m_cap = 1'b0;
      send_pixel(16'h5678);
      chk("disable_state", 32'(state), 32'd0);
      chk("disable_strobes", 32'(pix_cnt - pix0), 32'd1);
      end_line();
      vs_rise_steps(); vs_fall_steps();
      chk("disable_frame_cnt", 32'(frame_cnt), 32'd4);
      chk("disable_data_hold", 32'(pix_data), 32'h00001234);

      // Reset pulsed mid-line.
      enable = 1'b1;
      repeat (2) step();
      send_byte(8'h11);
      send_byte(8'h22);
      rst = 1'b1;
      send_byte(8'h33);
      check_zero("midline_reset");
      rst = 1'b0;
      href = 1'b0;
      repeat (2) step();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
